// File: rtl/right_shift_unit.sv
// ---------------------------------------------------------------------------
// right_shift_unit
//
// Multi-cycle 32-bit right shifter for the toy MIPS datapath (SRL/SRA/SRLV/
// SRAV). The five log-stages of a barrel shifter (1, 2, 4, 8, 16) are applied
// one per clock so the ALU critical path only ever sees a single stage.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous, active-high reset
//   start_i   request a shift; accepted only while busy_o is low
//   arith_i   1 = arithmetic (sign fill), 0 = logical (zero fill)
//   amount_i  shift distance 0..31
//   data_i    operand to shift
//   busy_o    operation in progress; start_i is ignored
//   done_o    one-cycle pulse; out_o holds the new result
//   out_o     registered result, held until the next completion
// ---------------------------------------------------------------------------
module right_shift_unit #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         arith_i,
    input  logic [4:0]   amount_i,
    input  logic [N-1:0] data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] out_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q;
    logic [N-1:0] work_q;
    logic [4:0]   amt_q;
    logic         arith_q;
    logic [N-1:0] out_q;

    logic         accept;
    logic         fill;
    logic [N-1:0] stageOut;

    // A new operation is taken whenever we are not mid-shift.
    assign accept = start_i && (state_q != SHIFT);

    // The fill bit never needs its own register: in arithmetic mode every
    // stage refills the top with the sign, so work_q[N-1] always still holds
    // the original data[31]; in logical mode the fill is simply zero.
    assign fill = arith_q & work_q[N-1];

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SHIFT runs for exactly five cycles (cnt 0..4), DONE
    // lasts one cycle and may chain straight into another operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd4) state_d = DONE;
            DONE:    state_d = start_i ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from the state register, so there is no
    // combinational path from any input.
    always_comb begin
        busy_o = (state_q == SHIFT);
        done_o = (state_q == DONE);
    end

    // One barrel stage, selected by the stage counter; the stage is applied
    // only when the matching bit of the latched amount is set.
    always_comb begin
        stageOut = work_q;
        case (cnt_q)
            3'd0: if (amt_q[0]) stageOut = {fill, work_q[N-1:1]};
            3'd1: if (amt_q[1]) stageOut = {{2{fill}}, work_q[N-1:2]};
            3'd2: if (amt_q[2]) stageOut = {{4{fill}}, work_q[N-1:4]};
            3'd3: if (amt_q[3]) stageOut = {{8{fill}}, work_q[N-1:8]};
            3'd4: if (amt_q[4]) stageOut = {{16{fill}}, work_q[N-1:16]};
            default: stageOut = work_q;
        endcase
    end

    // Datapath registers: operands are captured only on the accept edge, the
    // work register advances one stage per SHIFT cycle, and the result is
    // published to out_q only on the final stage so intermediate values are
    // never visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= 3'd0;
            work_q  <= '0;
            amt_q   <= 5'd0;
            arith_q <= 1'b0;
            out_q   <= '0;
        end else if (accept) begin
            cnt_q   <= 3'd0;
            work_q  <= data_i;
            amt_q   <= amount_i;
            arith_q <= arith_i;
        end else if (state_q == SHIFT) begin
            work_q <= stageOut;
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
                out_q <= stageOut;
            end
        end
    end

    assign out_o = out_q;

endmodule
